// File: rtl/mes_period_pkg.sv
// Shared frequency-measurement definitions: FSM state encoding and NPER-to-shift mapping.
// Pure declarations, no latency; no handshake involved.
// Imported by the period meter and by the generator/counter blocks.
`timescale 1ns/1ps
package mes_period_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } mes_state_t;

    localparam int EDGE_CNT_W = 4;

    // Averaging by a power of two collapses to a right shift of the accumulator.
    function automatic int nper_shift(input int nper);
        case (nper)
            2:       return 1;
            4:       return 2;
            8:       return 3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous input.
// Latency: redge is high in the 2nd clk after the input rises.
// No backpressure: redge is a one-clk strobe.
`timescale 1ns/1ps
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic redge
);

    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       sync_dly_q, sync_dly_d;
    logic [1:0] fill_q, fill_d;

    always_comb begin
        meta_d     = async_in;
        sync_d     = meta_q;
        sync_dly_d = sync_q;
        fill_d     = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            fill_q     <= 2'd0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            sync_dly_q <= sync_dly_d;
            fill_q     <= fill_d;
        end
    end

    // The first 0->1 of sync after reset is only the pipeline filling, not a real edge.
    assign redge = sync_q & ~sync_dly_q & (fill_q == 2'd3);

endmodule

// File: rtl/mes_period.sv
// Averaged MX period meter: counts ce ticks across NPER MX periods, reports the mean.
// Latency: valid one clk after the closing MX edge is detected (<=4 clk after the edge).
// No backpressure: start is dropped while busy or in the done clk; valid is a one-clk pulse.
`timescale 1ns/1ps
module mes_period
    import mes_period_pkg::*;
#(
    parameter int W    = 16,
    parameter int NPER = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         MX,
    input  logic         start,
    output logic [W-1:0] per,
    output logic         valid,
    output logic         busy,
    output logic         ovf
);

    localparam int SH = nper_shift(NPER);
    localparam int AW = W + SH;
    localparam logic [EDGE_CNT_W-1:0] LAST_EDGE = EDGE_CNT_W'(NPER - 1);

    logic                  redge;
    logic                  acc_full;
    mes_state_t            state_q, state_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [W-1:0]          per_q, per_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;

    sync_edge u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (MX),
        .redge    (redge)
    );

    assign acc_full = &acc_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        edge_cnt_d = edge_cnt_q;
        per_d      = per_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ARM;
                    acc_d      = '0;
                    edge_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            ST_ARM: begin
                if (redge) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (ce && !acc_full) begin
                    acc_d = acc_q + AW'(1);
                end
                if (redge) begin
                    edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(1);
                end
                // A tick landing with the closing edge is already in acc_d, so it is reported.
                if (ce && acc_full) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    ovf_d   = 1'b1;
                    per_d   = '1;
                end else if (redge && (edge_cnt_q == LAST_EDGE)) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    ovf_d   = 1'b0;
                    per_d   = W'(acc_d >> SH);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            edge_cnt_q <= '0;
            per_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            edge_cnt_q <= edge_cnt_d;
            per_q      <= per_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign per   = per_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_mes_period.sv
// Directed bench for mes_period: hand-computed periods, saturation, reset abort, ignored starts.
`timescale 1ns/1ps
module tb_mes_period;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, MX;
    logic        start1, start4;
    logic [15:0] per1, per4;
    logic        valid1, valid4, busy1, busy4, ovf1, ovf4;

    logic auto_mode = 1'b0;
    logic ce_man    = 1'b0;
    logic mx_man    = 1'b0;
    int   cyc_cnt   = 0;
    int   mx_per    = 100;
    int   mx_off    = 0;
    int   mx_ph;
    logic mx_gen;

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        cyc_cnt = cyc_cnt + 1;
    end

    assign mx_ph  = (((cyc_cnt - mx_off) % mx_per) + mx_per) % mx_per;
    assign mx_gen = (mx_ph < (mx_per / 2));
    assign ce     = auto_mode ? ((cyc_cnt % 50) == 0) : ce_man;
    assign MX     = auto_mode ? mx_gen : mx_man;

    mes_period #(.W(16), .NPER(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .MX(MX), .start(start1),
        .per(per1), .valid(valid1), .busy(busy1), .ovf(ovf1)
    );

    mes_period #(.W(16), .NPER(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .MX(MX), .start(start4),
        .per(per4), .valid(valid4), .busy(busy4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic m);
        ce_man = c;
        mx_man = m;
        @(posedge clk);
        #1;
    endtask

    // Leaves dut1 in COUNT with an empty accumulator; ce pulses during ARM must be ignored.
    task automatic arm_count();
        repeat (3) cyc(1'b0, 1'b0);
        start1 = 1'b1;
        cyc(1'b0, 1'b0);
        start1 = 1'b0;
        repeat (3) cyc(1'b1, 1'b1);
    endtask

    task automatic man_meas(input int n_ce, input logic coin, input logic extra,
                            output logic [15:0] per_o, output logic v_close,
                            output logic b_close, output logic v_after);
        arm_count();
        for (int i = 0; i < n_ce; i++) begin
            start1 = (i == 0) ? extra : 1'b0;
            cyc(1'b1, 1'b1);
        end
        start1 = 1'b0;
        repeat (3) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(coin, 1'b1);
        v_close = valid1;
        b_close = busy1;
        per_o   = per1;
        start1  = extra;
        cyc(~coin, 1'b1);
        start1  = 1'b0;
        v_after = valid1;
    endtask

    task automatic wait_valid(input logic sel, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? valid4 : valid1) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p;
        logic        vc, bc, va, ok;
        int          n, vcnt;

        rst_n  = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_per1",   32'(per1),   32'd0);
        chk("rst_valid1", 32'(valid1), 32'd0);
        chk("rst_busy1",  32'(busy1),  32'd0);
        chk("rst_ovf1",   32'(ovf1),   32'd0);
        chk("rst_per4",   32'(per4),   32'd0);
        chk("rst_busy4",  32'(busy4),  32'd0);
        rst_n = 1'b1;
        repeat (5) cyc(1'b0, 1'b0);

        // Coincident tick counts toward the closing period; one clk later it does not.
        man_meas(10, 1'b1, 1'b0, p, vc, bc, va);
        chk("coin_per",        32'(p),  32'd11);
        chk("coin_valid",      32'(vc), 32'd1);
        chk("coin_busy_done",  32'(bc), 32'd0);
        chk("coin_valid_1clk", 32'(va), 32'd0);
        man_meas(10, 1'b0, 1'b0, p, vc, bc, va);
        chk("late_per",   32'(p),  32'd10);
        chk("late_valid", 32'(vc), 32'd1);

        // Extra starts during COUNT and in the DONE clk must be dropped.
        man_meas(7, 1'b0, 1'b1, p, vc, bc, va);
        chk("ign_per",         32'(p),  32'd7);
        chk("ign_valid",       32'(vc), 32'd1);
        chk("ign_valid_after", 32'(va), 32'd0);
        vcnt = 0;
        repeat (20) begin
            cyc(1'b1, 1'b1);
            vcnt += int'(valid1);
        end
        chk("ign_no_extra_valid", 32'(vcnt),  32'd0);
        chk("ign_busy_idle",      32'(busy1), 32'd0);
        chk("ign_per_held",       32'(per1),  32'd7);

        // Single edge then flat MX with ce every clk: saturates on the 65536th tick.
        arm_count();
        n  = 0;
        ok = 1'b0;
        while (n < 70000 && !ok) begin
            cyc(1'b1, 1'b1);
            n++;
            if (valid1 === 1'b1) ok = 1'b1;
        end
        chk("sat_valid_seen", 32'(ok),    32'd1);
        chk("sat_ticks",      32'(n),     32'd65536);
        chk("sat_per",        32'(per1),  32'hFFFF);
        chk("sat_ovf",        32'(ovf1),  32'd1);
        chk("sat_busy",       32'(busy1), 32'd0);

        // Reset mid-COUNT: outputs clear at once, no valid, MX high at release is no edge.
        arm_count();
        repeat (5) cyc(1'b1, 1'b1);
        chk("pre_rst_busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_per",   32'(per1),   32'd0);
        chk("arst_ovf",   32'(ovf1),   32'd0);
        chk("arst_busy",  32'(busy1),  32'd0);
        chk("arst_valid", 32'(valid1), 32'd0);
        vcnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            vcnt += int'(valid1);
        end
        rst_n  = 1'b1;
        start1 = 1'b1;
        cyc(1'b0, 1'b1);
        start1 = 1'b0;
        repeat (20) begin
            cyc(1'b0, 1'b1);
            vcnt += int'(valid1);
        end
        chk("rst_no_valid",  32'(vcnt),  32'd0);
        chk("rst_arm_waits", 32'(busy1), 32'd1);
        mx_per    = 2500;
        mx_off    = cyc_cnt - 2500 + 20;
        auto_mode = 1'b1;
        wait_valid(1'b0, 6000, ok);
        chk("post_rst_valid_seen", 32'(ok),   32'd1);
        chk("post_rst_per",        32'(per1), 32'd50);
        chk("post_rst_ovf",        32'(ovf1), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy1), 32'd0);

        // 100 us MX, NPER=1.
        mx_per = 5000;
        mx_off = cyc_cnt - 5000 + 20;
        repeat (5) @(posedge clk);
        #1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        chk("p100_busy",     32'(busy1), 32'd1);
        chk("p100_per_held", 32'(per1),  32'd50);
        wait_valid(1'b0, 12000, ok);
        chk("p100_valid_seen", 32'(ok),   32'd1);
        chk("p100_per",        32'(per1), 32'd100);
        chk("p100_ovf",        32'(ovf1), 32'd0);
        @(posedge clk);
        #1;
        chk("p100_valid_1clk", 32'(valid1), 32'd0);
        chk("p100_busy_after", 32'(busy1),  32'd0);

        // 37 us MX averaged over 4 periods.
        mx_per = 1850;
        mx_off = cyc_cnt - 1850 + 20;
        repeat (5) @(posedge clk);
        #1;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        chk("p37_busy", 32'(busy4), 32'd1);
        wait_valid(1'b1, 10000, ok);
        chk("p37_valid_seen", 32'(ok),   32'd1);
        chk("p37_per",        32'(per4), 32'd37);
        chk("p37_ovf",        32'(ovf4), 32'd0);
        @(posedge clk);
        #1;
        chk("p37_valid_1clk", 32'(valid4), 32'd0);
        chk("p37_busy_after", 32'(busy4),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
